// File: rtl/motion_sequencer.sv
// Multi-axis move sequencer: a small FIFO of move commands feeding a
// LOAD/ARM/RUN/DONE handshake with the per-axis stepper drivers.
module motion_sequencer #(
  parameter int NUM_AXES  = 4,
  parameter int DEPTH     = 4,
  parameter int SPEED_MIN = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic [32*NUM_AXES-1:0]          cmd_steps,
  input  logic [32*NUM_AXES-1:0]          cmd_speed,
  input  logic                            enable,
  input  logic                            abort,
  input  logic [NUM_AXES-1:0]             axis_driving,
  output logic [32*NUM_AXES-1:0]          axis_steps,
  output logic [32*NUM_AXES-1:0]          axis_speed,
  output logic                            axis_start,
  output logic                            axis_enable,
  output logic                            busy,
  output logic                            move_done,
  output logic [$clog2(DEPTH):0]          queue_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = 32 * NUM_AXES;

  typedef enum logic [2:0] {IDLE, LOAD, ARM, RUN, DONE, ABORT} state_t;

  state_t          state_q;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH-1:0][BW-1:0] steps_mem, speed_mem;
  logic [BW-1:0]   axis_steps_q, axis_speed_q;
  logic            axis_start_q, axis_enable_q, move_done_q;
  logic            push, pop;

  // Speeds below the driver's minimum half-period are raised to it (0 would wrap the counter).
  function automatic logic [31:0] clamp_speed(input logic [31:0] s);
    return (s < 32'(SPEED_MIN)) ? 32'(SPEED_MIN) : s;
  endfunction

  assign cmd_ready   = (count_q < CW'(DEPTH)) && (state_q != ABORT);
  assign axis_steps  = axis_steps_q;
  assign axis_speed  = axis_speed_q;
  assign axis_start  = axis_start_q;
  assign axis_enable = axis_enable_q;
  assign move_done   = move_done_q;
  assign busy        = (state_q != IDLE);
  assign queue_count = count_q;

  // FIFO bookkeeping; an abort flushes everything, including a push offered in the same cycle.
  always_comb begin
    push     = cmd_valid && cmd_ready && !abort;
    pop      = (state_q == IDLE) && enable && (count_q != '0) && !abort;
    count_d  = count_q + CW'(push) - CW'(pop);
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    if (abort) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // FIFO storage; contents are only meaningful below count_q, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      steps_mem[wr_ptr_q] <= cmd_steps;
      speed_mem[wr_ptr_q] <= cmd_speed;
    end
  end

  // Move sequencer FSM with registered driver-facing outputs; abort beats every transition.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      axis_steps_q  <= '0;
      axis_speed_q  <= '0;
      axis_start_q  <= 1'b0;
      axis_enable_q <= 1'b0;
      move_done_q   <= 1'b0;
    end else if (abort) begin
      state_q       <= ABORT;
      axis_start_q  <= 1'b0;
      axis_enable_q <= 1'b0;
      move_done_q   <= 1'b0;
    end else begin
      axis_enable_q <= 1'b1;
      case (state_q)
        IDLE: if (pop) begin
          axis_steps_q <= steps_mem[rd_ptr_q];
          for (int a = 0; a < NUM_AXES; a++)
            axis_speed_q[a*32 +: 32] <= clamp_speed(speed_mem[rd_ptr_q][a*32 +: 32]);
          axis_start_q <= 1'b1;
          state_q      <= LOAD;
        end
        LOAD: begin
          axis_start_q <= 1'b0;
          state_q      <= ARM;
        end
        // Start low for a cycle so drivers clear their start-seen flag before we watch driving.
        ARM: state_q <= RUN;
        RUN: if (axis_driving == '0) begin
          move_done_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          move_done_q <= 1'b0;
          state_q     <= IDLE;
        end
        ABORT: begin
          // Power stage stays off until every driver has actually stopped.
          axis_enable_q <= (axis_driving == '0);
          if (axis_driving == '0) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
